// File: rtl/ibex_mem_responder.sv
// Responder for the Ibex instruction and data memory interfaces.
// Arbitrates both initiator ports onto one single-port RAM with 1-cycle read
// latency. Requests outside the RAM window are granted and answered with an
// error. Optional grant wait states are supported, and each response is routed
// back to the port that issued it.
module ibex_mem_responder #(
    parameter logic [31:0] MEM_START = 32'h0000_0000,
    parameter int unsigned MEM_SIZE  = 64 * 1024,
    parameter int unsigned GNT_WAIT  = 0
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,

    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_gnt,
    output logic        instr_rvalid,
    output logic [31:0] instr_rdata,
    output logic        instr_err,

    input  logic        data_req,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        data_err,

    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        proto_err
);

    localparam logic [31:0] ADDR_MASK   = ~(32'(MEM_SIZE) - 32'd1);
    localparam logic [3:0]  WAIT_CYCLES = 4'(GNT_WAIT);

    typedef enum logic { ST_IDLE, ST_WAIT } state_e;
    typedef enum logic { PORT_INSTR, PORT_DATA } port_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    port_e       owner_q, owner_d;
    port_e       last_gnt_q;
    logic        proto_err_q, proto_err_d;

    port_e       pick;
    port_e       gnt_port;
    logic        grant;
    logic        owner_req;

    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        in_range;

    logic        rsp_valid_q;
    port_e       rsp_port_q;
    logic        rsp_err_q;
    logic        rsp_we_q;
    logic        rsp_load_ok;

    // Arbitration FSM: choose the owner, count wait states, and detect dropped requests.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        owner_d     = owner_q;
        proto_err_d = proto_err_q;
        grant       = 1'b0;
        gnt_port    = owner_q;
        owner_req   = (owner_q == PORT_INSTR) ? instr_req : data_req;

        if (instr_req && data_req) begin
            pick = (last_gnt_q == PORT_DATA) ? PORT_INSTR : PORT_DATA;
        end else begin
            pick = instr_req ? PORT_INSTR : PORT_DATA;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (instr_req || data_req) begin
                    if (WAIT_CYCLES == 4'd0) begin
                        grant    = 1'b1;
                        gnt_port = pick;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = 4'd1;
                        owner_d    = pick;
                    end
                end
            end
            ST_WAIT: begin
                if (!owner_req) begin
                    proto_err_d = 1'b1;
                    state_d     = ST_IDLE;
                    wait_cnt_d  = '0;
                end else if (wait_cnt_q == WAIT_CYCLES) begin
                    grant      = 1'b1;
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase

        // The combinational grant must not leak out while reset is held.
        if (!rst_sys_n) begin
            grant = 1'b0;
        end
    end

    // Request mux and RAM-side strobes; mem_* stay quiet unless a grant is issued.
    always_comb begin
        if (gnt_port == PORT_INSTR) begin
            sel_we    = 1'b0;
            sel_be    = 4'hF;
            sel_addr  = instr_addr;
            sel_wdata = '0;
        end else begin
            sel_we    = data_we;
            sel_be    = data_be;
            sel_addr  = data_addr;
            sel_wdata = data_wdata;
        end

        in_range  = (sel_addr & ADDR_MASK) == MEM_START;

        instr_gnt = grant && (gnt_port == PORT_INSTR);
        data_gnt  = grant && (gnt_port == PORT_DATA);

        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant) begin
            mem_req   = in_range;
            mem_we    = sel_we;
            mem_be    = sel_be;
            mem_addr  = sel_addr;
            mem_wdata = sel_wdata;
        end
    end

    // Arbitration state, fairness pointer, and sticky protocol error.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            owner_q     <= PORT_INSTR;
            last_gnt_q  <= PORT_DATA;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            owner_q     <= owner_d;
            proto_err_q <= proto_err_d;
            if (grant) begin
                last_gnt_q <= gnt_port;
            end
        end
    end

    // One-entry response stage, overwritten on every grant and emptied otherwise.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= PORT_INSTR;
            rsp_err_q   <= 1'b0;
            rsp_we_q    <= 1'b0;
        end else begin
            rsp_valid_q <= grant;
            if (grant) begin
                rsp_port_q <= gnt_port;
                rsp_err_q  <= ~in_range;
                rsp_we_q   <= sel_we;
            end
        end
    end

    // Route the response to its issuing port; only good loads return RAM data.
    always_comb begin
        rsp_load_ok  = rsp_valid_q && !rsp_err_q && !rsp_we_q;
        instr_rvalid = rsp_valid_q && (rsp_port_q == PORT_INSTR);
        data_rvalid  = rsp_valid_q && (rsp_port_q == PORT_DATA);
        instr_err    = instr_rvalid && rsp_err_q;
        data_err     = data_rvalid && rsp_err_q;
        instr_rdata  = (instr_rvalid && rsp_load_ok) ? mem_rdata : '0;
        data_rdata   = (data_rvalid && rsp_load_ok) ? mem_rdata : '0;
        proto_err    = proto_err_q;
    end

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Directed bench for ibex_mem_responder.
// Three instances (GNT_WAIT = 0, 3, 2) share the stimulus.
// Instance 0 is backed by a byte-enabled RAM model.
// Instances 1 and 2 see a constant read word.
module tb_ibex_mem_responder;

    localparam int unsigned WAITS [3] = '{0, 3, 2};
    localparam logic [31:0] FIXED_WORD = 32'hCAFE_F00D;

    logic        clk_sys = 1'b0;
    logic        rst_sys_n;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;

    logic        instr_gnt    [3];
    logic        instr_rvalid [3];
    logic [31:0] instr_rdata  [3];
    logic        instr_err    [3];
    logic        data_gnt     [3];
    logic        data_rvalid  [3];
    logic [31:0] data_rdata   [3];
    logic        data_err     [3];
    logic        mem_req      [3];
    logic        mem_we       [3];
    logic [3:0]  mem_be       [3];
    logic [31:0] mem_addr     [3];
    logic [31:0] mem_wdata    [3];
    logic [31:0] mem_rdata    [3];
    logic        proto_err    [3];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // RAM for instance 0. It holds each word XORed with its index pattern,
    // so the zero-initialised array reads back as {16'hBEEF, word index}.
    bit [31:0] ram_delta [16384];
    bit [31:0] ram_q;

    always #5 clk_sys = ~clk_sys;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ibex_mem_responder #(
            .MEM_START (32'h0000_0000),
            .MEM_SIZE  (64 * 1024),
            .GNT_WAIT  (WAITS[g])
        ) u_dut (
            .clk_sys      (clk_sys),
            .rst_sys_n    (rst_sys_n),
            .instr_req    (instr_req),
            .instr_addr   (instr_addr),
            .instr_gnt    (instr_gnt[g]),
            .instr_rvalid (instr_rvalid[g]),
            .instr_rdata  (instr_rdata[g]),
            .instr_err    (instr_err[g]),
            .data_req     (data_req),
            .data_we      (data_we),
            .data_be      (data_be),
            .data_addr    (data_addr),
            .data_wdata   (data_wdata),
            .data_gnt     (data_gnt[g]),
            .data_rvalid  (data_rvalid[g]),
            .data_rdata   (data_rdata[g]),
            .data_err     (data_err[g]),
            .mem_req      (mem_req[g]),
            .mem_we       (mem_we[g]),
            .mem_be       (mem_be[g]),
            .mem_addr     (mem_addr[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_rdata    (mem_rdata[g]),
            .proto_err    (proto_err[g])
        );
        if (g == 0) begin : g_ram
            assign mem_rdata[g] = ram_q;
        end else begin : g_fixed
            assign mem_rdata[g] = FIXED_WORD;
        end
    end

    // Single-port RAM: the read data appears the cycle after mem_req, and writes honour byte enables.
    always @(posedge clk_sys) begin
        bit [13:0] idx;
        bit [31:0] pat;
        bit [31:0] word;
        if (mem_req[0]) begin
            idx  = mem_addr[0][15:2];
            pat  = {16'hBEEF, 2'b00, idx};
            word = ram_delta[idx] ^ pat;
            if (mem_we[0]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[0][b]) word[8*b +: 8] = mem_wdata[0][8*b +: 8];
                end
                ram_delta[idx] <= word ^ pat;
            end
            ram_q <= word;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req  = 1'b0;
        instr_addr = '0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_be    = '0;
        data_addr  = '0;
        data_wdata = '0;
    endtask

    task automatic reset_all();
        cyc();
        rst_sys_n = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        rst_sys_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit exp_i;
        rst_sys_n = 1'b0;
        idle_inputs();
        #3;
        check_eq("rst_instr_gnt",    32'(instr_gnt[0]),    32'd0);
        check_eq("rst_data_gnt",     32'(data_gnt[0]),     32'd0);
        check_eq("rst_instr_rvalid", 32'(instr_rvalid[0]), 32'd0);
        check_eq("rst_data_rvalid",  32'(data_rvalid[0]),  32'd0);
        check_eq("rst_mem_req",      32'(mem_req[0]),      32'd0);
        check_eq("rst_mem_addr",     mem_addr[0],          32'd0);
        check_eq("rst_proto_err",    32'(proto_err[0]),    32'd0);
        cyc();
        cyc();
        rst_sys_n = 1'b1;

        // Test 1: a single fetch is granted in the same cycle and answered the next cycle.
        cyc();
        instr_req = 1'b1; instr_addr = 32'h80;
        #1;
        check_eq("t1_instr_gnt", 32'(instr_gnt[0]), 32'd1);
        check_eq("t1_data_gnt",  32'(data_gnt[0]),  32'd0);
        check_eq("t1_mem_req",   32'(mem_req[0]),   32'd1);
        check_eq("t1_mem_addr",  mem_addr[0],       32'h80);
        check_eq("t1_mem_we",    32'(mem_we[0]),    32'd0);
        check_eq("t1_mem_be",    32'(mem_be[0]),    32'hF);
        cyc();
        idle_inputs();
        #1;
        check_eq("t1_instr_rvalid", 32'(instr_rvalid[0]), 32'd1);
        check_eq("t1_instr_rdata",  instr_rdata[0],       32'hBEEF_0020);
        check_eq("t1_instr_err",    32'(instr_err[0]),    32'd0);
        check_eq("t1_data_rvalid",  32'(data_rvalid[0]),  32'd0);

        // Test 2: with both ports requesting, grants alternate I, D, I, D.
        reset_all();
        for (int k = 0; k < 4; k++) begin
            cyc();
            instr_req = 1'b1; instr_addr = 32'h40;
            data_req  = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h44;
            #1;
            exp_i = (k % 2) == 0;
            check_eq("t2_instr_gnt", 32'(instr_gnt[0]), 32'(exp_i));
            check_eq("t2_data_gnt",  32'(data_gnt[0]),  32'(!exp_i));
            if (k > 0) begin
                check_eq("t2_instr_rvalid", 32'(instr_rvalid[0]), 32'(!exp_i));
                check_eq("t2_data_rvalid",  32'(data_rvalid[0]),  32'(exp_i));
                check_eq("t2_instr_rdata",  instr_rdata[0], exp_i ? 32'h0 : 32'hBEEF_0010);
                check_eq("t2_data_rdata",   data_rdata[0],  exp_i ? 32'hBEEF_0011 : 32'h0);
            end
        end
        cyc();
        idle_inputs();
        #1;
        check_eq("t2_last_data_rvalid",  32'(data_rvalid[0]),  32'd1);
        check_eq("t2_last_data_rdata",   data_rdata[0],        32'hBEEF_0011);
        check_eq("t2_last_instr_rvalid", 32'(instr_rvalid[0]), 32'd0);

        // Test 3: a byte-enabled store, then a load back from the same word.
        cyc();
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
        data_addr = 32'h100; data_wdata = 32'hA5A5_1234;
        #1;
        check_eq("t3_st_gnt",     32'(data_gnt[0]), 32'd1);
        check_eq("t3_st_mem_req", 32'(mem_req[0]),  32'd1);
        check_eq("t3_st_mem_we",  32'(mem_we[0]),   32'd1);
        check_eq("t3_st_mem_be",  32'(mem_be[0]),   32'h3);
        check_eq("t3_st_wdata",   mem_wdata[0],     32'hA5A5_1234);
        check_eq("t3_st_addr",    mem_addr[0],      32'h100);
        cyc();
        data_we = 1'b0; data_be = 4'hF; data_wdata = '0;
        #1;
        check_eq("t3_st_rvalid", 32'(data_rvalid[0]), 32'd1);
        check_eq("t3_st_rdata",  data_rdata[0],       32'h0);
        check_eq("t3_st_err",    32'(data_err[0]),    32'd0);
        check_eq("t3_ld_gnt",    32'(data_gnt[0]),    32'd1);

        // Last in-range word, then the first address past the 64 kB window.
        cyc();
        data_addr = 32'h0000_FFFC;
        #1;
        check_eq("t3_ld_rvalid", 32'(data_rvalid[0]), 32'd1);
        check_eq("t3_ld_rdata",  data_rdata[0],       32'hBEEF_1234);
        check_eq("edge_mem_req", 32'(mem_req[0]),     32'd1);
        cyc();
        data_addr = 32'h0001_0000;
        #1;
        check_eq("edge_rdata",  data_rdata[0],      32'hBEEF_3FFF);
        check_eq("edge_err",    32'(data_err[0]),   32'd0);
        check_eq("t4_gnt",      32'(data_gnt[0]),   32'd1);
        check_eq("t4_mem_req",  32'(mem_req[0]),    32'd0);
        cyc();
        idle_inputs();
        #1;
        check_eq("t4_rvalid", 32'(data_rvalid[0]), 32'd1);
        check_eq("t4_err",    32'(data_err[0]),    32'd1);
        check_eq("t4_rdata",  data_rdata[0],       32'h0);
        check_eq("t4_mem_req_idle", 32'(mem_req[0]), 32'd0);

        // Test 5: with GNT_WAIT = 3 the owner is locked; data waits for its own window.
        reset_all();
        for (int k = 1; k <= 4; k++) begin
            cyc();
            instr_req = 1'b1; instr_addr = 32'h80;
            data_req  = (k >= 2); data_we = 1'b0; data_be = 4'hF; data_addr = 32'h84;
            #1;
            check_eq("t5_instr_gnt", 32'(instr_gnt[1]), 32'(k == 4));
            check_eq("t5_data_gnt",  32'(data_gnt[1]),  32'd0);
        end
        check_eq("t5_mem_addr_i", mem_addr[1], 32'h80);
        for (int k = 5; k <= 8; k++) begin
            cyc();
            instr_req = 1'b0;
            #1;
            check_eq("t5_data_gnt2",  32'(data_gnt[1]),  32'(k == 8));
            check_eq("t5_instr_gnt2", 32'(instr_gnt[1]), 32'd0);
            if (k == 5) begin
                check_eq("t5_instr_rvalid", 32'(instr_rvalid[1]), 32'd1);
                check_eq("t5_instr_rdata",  instr_rdata[1],       FIXED_WORD);
            end
        end
        check_eq("t5_mem_addr_d", mem_addr[1], 32'h84);
        cyc();
        idle_inputs();
        #1;
        check_eq("t5_data_rvalid", 32'(data_rvalid[1]), 32'd1);
        check_eq("t5_data_rdata",  data_rdata[1],       FIXED_WORD);

        // Test 6: with GNT_WAIT = 2, dropping the request before its grant sets a sticky proto_err.
        reset_all();
        cyc();
        data_req = 1'b1; data_addr = 32'h100; data_we = 1'b0; data_be = 4'hF;
        #1;
        check_eq("t6_gnt_early", 32'(data_gnt[2]), 32'd0);
        cyc();
        data_req = 1'b0;
        #1;
        check_eq("t6_gnt_drop",   32'(data_gnt[2]),  32'd0);
        check_eq("t6_perr_drop",  32'(proto_err[2]), 32'd0);
        cyc();
        check_eq("t6_perr_set",   32'(proto_err[2]), 32'd1);
        check_eq("t6_no_rvalid",  32'(data_rvalid[2]), 32'd0);
        cyc();
        cyc();
        check_eq("t6_perr_stick", 32'(proto_err[2]), 32'd1);
        check_eq("t6_no_gnt",     32'(data_gnt[2]),  32'd0);

        // Reset asserted while a fetch waits for its grant.
        cyc();
        instr_req = 1'b1; instr_addr = 32'h80;
        cyc();
        check_eq("t6_wait_gnt", 32'(instr_gnt[2]), 32'd0);
        rst_sys_n = 1'b0;
        #1;
        check_eq("t6_rst_instr_gnt0", 32'(instr_gnt[0]),    32'd0);
        check_eq("t6_rst_instr_gnt",  32'(instr_gnt[2]),    32'd0);
        check_eq("t6_rst_rvalid",     32'(instr_rvalid[2]), 32'd0);
        check_eq("t6_rst_mem_req",    32'(mem_req[2]),      32'd0);
        check_eq("t6_rst_perr",       32'(proto_err[2]),    32'd0);
        cyc();
        idle_inputs();
        rst_sys_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check_eq("t6_post_rvalid", 32'(instr_rvalid[2]), 32'd0);
            check_eq("t6_post_gnt",    32'(instr_gnt[2]),    32'd0);
            check_eq("t6_post_perr",   32'(proto_err[2]),    32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
